ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Memory-side responder for the 8-bit CPU RAM bus: 256x8 storage, write/read strobes active-low, one shared bidirectional data bus.
- Answers CPU reads by driving the data bus and commits CPU writes on the clock edge.
- Adds a front-panel load sequencer so a program can be keyed in byte-by-byte before the CPU runs.
- Sits between the CPU datapath and the board's switch/LED panel.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- DATA_W, 8, data width.
- SYNC_STAGES, 2, flip-flop stages in the load_strobe synchronizer (minimum 2).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-low reset.
- addr, input, ADDR_W, CPU address (MAR output).
- data, inout, DATA_W, shared CPU data bus.
- ram_w, input, 1, active-low write strobe from the CPU.
- ram_r, input, 1, active-low read strobe from the CPU.
- load_en, input, 1, level: 1 = front-panel load mode.
- load_data, input, DATA_W, byte from the key switches.
- load_strobe, input, 1, asynchronous key press; rising edge = store one byte.
- load_addr, output, ADDR_W, next address the load sequencer will write.
- busy, output, 1, 1 while not in RUN (CPU accesses are ignored).
- collision, output, 1, sticky flag: ram_r and ram_w were both low in RUN.

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-low.
- On reset:
  - state=RUN (CLEAR with RAM_CLEAR_EN), load_addr=0, collision=0, synchronizer and edge-detect flops=0.
  - busy=0 (1 with RAM_CLEAR_EN).
  - data bus released (Z).
- State machine states: RUN, LOAD (plus CLEAR under macro).
  - RUN -> LOAD when load_en=1 is sampled; load_addr cleared to 0 on that same edge.
  - LOAD -> RUN when load_en=0 is sampled; a strobe edge detected on that cycle is discarded.
  - load_en overrides everything except CLEAR.
- RUN read:
  - Condition: ram_r=0 and ram_w=1.
  - data = mem[addr], combinational, same cycle, no latency.
  - data is otherwise Z.
- RUN write:
  - Condition: ram_w=0 and ram_r=1.
  - mem[addr] <= data at the rising edge.
  - Value is readable on the next cycle.
- Collision:
  - Condition: ram_r=0 and ram_w=0 in RUN.
  - No drive, no write; collision <= 1 and stays 1 until reset.
- LOAD:
  - data always Z; CPU strobes are ignored.
  - load_strobe passes through SYNC_STAGES flops, then a rising-edge detect.
  - On a detected edge: mem[load_addr] <= load_data, and load_addr <= load_addr+1 on the same edge.
  - Latency: the write occurs SYNC_STAGES+1 edges after the strobe rises.
  - load_addr wraps 255 -> 0 with no flag.
  - A strobe held high produces exactly one write.
- Reset mid-LOAD: returns to RUN (or CLEAR); bytes already written are kept (without the macro).
- Reset while the CPU is strobing: the bus is released on that edge.
- Write width is exactly DATA_W; no partial writes.

Optional Feature:
- RAM_CLEAR_EN defined:
  - Reset enters CLEAR with busy=1.
  - A counter writes 0 to every address, one per cycle, 0..2**ADDR_W-1 (256 cycles).
  - Then RUN with busy=0.
  - load_en and CPU strobes are ignored during CLEAR.
  - Reset during CLEAR restarts the sweep at 0.
- Undefined:
  - No CLEAR state; memory contents survive reset.
  - busy is 1 only in LOAD.

Test Plan:
- RUN write/read: addr=0x10, data=0x5A, ram_w=0 for one cycle; then ram_r=0 -> data=0x5A in the same cycle; with both strobes high data=Z.
- Load sequence: load_en=1, load_data 0x11, 0x22, 0x33 with one strobe pulse each -> load_addr=3, busy=1; load_en=0, then CPU reads of addr 0/1/2 return 0x11/0x22/0x33.
- Strobe latency/hold: strobe held high for 10 cycles -> exactly one write, committed SYNC_STAGES+1 edges after the rise; load_addr increments by 1.
- Wrap: load 256 bytes, then one more (0xEE) -> load_addr returns to 0 then 1; mem[0]=0xEE.
- Collision: ram_r=0 and ram_w=0 at addr 0x20 with CPU driving 0x77 -> mem[0x20] unchanged, data not driven, collision=1 until rst=0.
- Reset mid-load and the macro: rst low after 2 loaded bytes -> RUN, load_addr=0, bytes kept. With RAM_CLEAR_EN, busy=1 for 256 cycles, then every address reads 0x00.

Source files
------------

// File: rtl/ram_responder.sv
// 256x8 CPU RAM responder with front-panel byte loader.
// Define RAM_CLEAR_EN to zero the whole array after every reset.
module ram_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    input  logic              ram_w,
    input  logic              ram_r,
    input  logic              load_en,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_strobe,
    output logic [ADDR_W-1:0] load_addr,
    output logic              busy,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef RAM_CLEAR_EN
    typedef enum logic [1:0] {RUN, LOAD, CLEAR} state_t;
    localparam state_t RST_STATE = CLEAR;
`else
    typedef enum logic [1:0] {RUN, LOAD} state_t;
    localparam state_t RST_STATE = RUN;
`endif

    state_t state, next_state;

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   strobe_rise;
    logic                   rd_en;
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic [ADDR_W-1:0]      next_load_addr;
    logic                   col_set;
`ifdef RAM_CLEAR_EN
    logic [ADDR_W-1:0]      clr_cnt, next_clr;
`endif

    // Key press is asynchronous: synchronize, then detect the rising edge once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], load_strobe};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign strobe_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Read drive kept apart from the write path so the bus never loops back.
    assign rd_en = rst && (state == RUN) && !load_en && !ram_r && ram_w;
    assign data  = rd_en ? mem[addr] : {DATA_W{1'bz}};
    assign busy  = (state != RUN);

    always_comb begin
        next_state     = state;
        next_load_addr = load_addr;
        we             = 1'b0;
        waddr          = addr;
        wdata          = data;
        col_set        = 1'b0;
`ifdef RAM_CLEAR_EN
        next_clr       = clr_cnt;
`endif
        unique case (state)
            RUN: begin
                if (load_en) begin
                    next_state     = LOAD;
                    next_load_addr = '0;
                end else if (!ram_r && !ram_w) begin
                    col_set = 1'b1;
                end else if (!ram_w) begin
                    we = 1'b1;
                end
            end
            LOAD: begin
                if (!load_en) begin
                    next_state = RUN;
                end else if (strobe_rise) begin
                    we             = 1'b1;
                    waddr          = load_addr;
                    wdata          = load_data;
                    next_load_addr = load_addr + 1'b1;
                end
            end
`ifdef RAM_CLEAR_EN
            CLEAR: begin
                we       = 1'b1;
                waddr    = clr_cnt;
                wdata    = '0;
                next_clr = clr_cnt + 1'b1;
                if (clr_cnt == '1) next_state = RUN;
            end
`endif
            default: ;
        endcase
        if (!rst) we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RST_STATE;
            load_addr <= '0;
            collision <= 1'b0;
        end else begin
            state     <= next_state;
            load_addr <= next_load_addr;
            if (col_set) collision <= 1'b1;
        end
    end

`ifdef RAM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!rst) clr_cnt <= '0;
        else      clr_cnt <= next_clr;
    end
`endif

    // Storage has no reset: contents survive reset unless swept by CLEAR.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_ram_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    wire  [7:0] data;
    logic [7:0] cpu_d;
    logic       cpu_oe;
    logic       ram_w;
    logic       ram_r;
    logic       load_en;
    logic [7:0] load_data;
    logic       load_strobe;
    logic [7:0] load_addr;
    logic       busy;
    logic       collision;

    always #5 clk = ~clk;

    assign data = cpu_oe ? cpu_d : 8'hzz;

    ram_responder dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data       (data),
        .ram_w      (ram_w),
        .ram_r      (ram_r),
        .load_en    (load_en),
        .load_data  (load_data),
        .load_strobe(load_strobe),
        .load_addr  (load_addr),
        .busy       (busy),
        .collision  (collision)
    );

    localparam int S_DATA = 0;
    localparam int S_LA   = 1;
    localparam int S_BUSY = 2;
    localparam int S_COL  = 3;
    localparam int S_Z    = 4;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } item_t;

    item_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

`ifdef RAM_CLEAR_EN
    localparam logic RST_BUSY = 1'b1;
`else
    localparam logic RST_BUSY = 1'b0;
`endif

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            item_t      it;
            logic [7:0] act;
            logic       ok;
            it = sb.pop_front();
            ok = 1'b0;
            act = 8'h00;
            case (it.sel)
                S_DATA: begin act = data; ok = (data === it.exp); end
                S_LA:   begin act = load_addr; ok = (load_addr === it.exp); end
                S_BUSY: begin act = {7'd0, busy}; ok = ({7'd0, busy} === it.exp); end
                S_COL:  begin act = {7'd0, collision}; ok = ({7'd0, collision} === it.exp); end
                default: begin act = data; ok = (data === 8'hzz); end
            endcase
            n_cmp++;
            if (!ok) begin
                n_bad++;
                if (it.sel == S_Z)
                    $display("FAIL %s: got %h want zz", it.name, act);
                else
                    $display("FAIL %s: got %h want %h", it.name, act, it.exp);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int sel, input logic [7:0] exp);
        item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        addr   = a;
        cpu_d  = d;
        cpu_oe = 1'b1;
        ram_w  = 1'b0;
        tick();
        ram_w  = 1'b1;
        cpu_oe = 1'b0;
    endtask

    task automatic cpu_read(input string name, input logic [7:0] a,
                            input logic [7:0] exp);
        addr  = a;
        ram_r = 1'b0;
        chk(name, S_DATA, exp);
        tick();
        ram_r = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] b);
        load_data   = b;
        load_strobe = 1'b1;
        tick();
        load_strobe = 1'b0;
        repeat (4) tick();
    endtask

`ifdef RAM_CLEAR_EN
    task automatic wait_clear;
        chk("clr_busy_start", S_BUSY, 8'd1);
        repeat (255) tick();
        chk("clr_busy_last", S_BUSY, 8'd1);
        tick();
        chk("clr_busy_done", S_BUSY, 8'd0);
        tick();
    endtask
`endif

    initial begin
        rst = 1'b0; addr = 8'h00; cpu_d = 8'h00; cpu_oe = 1'b0;
        ram_w = 1'b1; ram_r = 1'b1; load_en = 1'b0;
        load_data = 8'h00; load_strobe = 1'b0;

        tick(); tick();
        chk("rst_busy", S_BUSY, {7'd0, RST_BUSY});
        chk("rst_la",   S_LA,   8'h00);
        chk("rst_col",  S_COL,  8'h00);
        chk("rst_z",    S_Z,    8'h00);
        tick();
        rst = 1'b1;
`ifdef RAM_CLEAR_EN
        wait_clear();
        cpu_read("clr_rd10", 8'h10, 8'h00);
        cpu_read("clr_rdff", 8'hFF, 8'h00);
`endif

        cpu_write(8'h10, 8'h5A);
        cpu_read("run_rd10", 8'h10, 8'h5A);
        chk("idle_z", S_Z, 8'h00);
        tick();

        cpu_write(8'h20, 8'h33);
        addr = 8'h20; cpu_d = 8'h77; cpu_oe = 1'b1;
        ram_r = 1'b0; ram_w = 1'b0;
        chk("col_bus", S_DATA, 8'h77);
        chk("col_pre", S_COL,  8'h00);
        tick();
        ram_r = 1'b1; ram_w = 1'b1; cpu_oe = 1'b0;
        chk("col_set", S_COL, 8'h01);
        tick();
        cpu_read("col_mem", 8'h20, 8'h33);

        load_en = 1'b1;
        tick();
        chk("ld_busy", S_BUSY, 8'd1);
        chk("ld_la0",  S_LA,   8'h00);
        pulse(8'h11); pulse(8'h22); pulse(8'h33);
        chk("ld_la3",   S_LA,   8'h03);
        chk("ld_busy3", S_BUSY, 8'd1);
        load_en = 1'b0;
        tick();
        chk("ld_run", S_BUSY, 8'd0);
        cpu_read("ld_rd0", 8'h00, 8'h11);
        cpu_read("ld_rd1", 8'h01, 8'h22);
        cpu_read("ld_rd2", 8'h02, 8'h33);

        load_en = 1'b1;
        tick();
        load_data = 8'hA5; load_strobe = 1'b1;
        chk("lat_e0", S_LA, 8'h00);
        tick();
        chk("lat_e1", S_LA, 8'h00);
        tick();
        chk("lat_e2", S_LA, 8'h00);
        tick();
        chk("lat_e3", S_LA, 8'h01);
        repeat (7) tick();
        chk("hold_la", S_LA, 8'h01);
        load_strobe = 1'b0;
        repeat (4) tick();
        chk("hold_after", S_LA, 8'h01);
        load_en = 1'b0;
        tick();
        cpu_read("hold_rd0", 8'h00, 8'hA5);
        cpu_read("hold_rd1", 8'h01, 8'h22);

        load_en = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) pulse(8'(i) ^ 8'h3C);
        chk("wrap_la0", S_LA, 8'h00);
        pulse(8'hEE);
        chk("wrap_la1", S_LA, 8'h01);
        load_en = 1'b0;
        tick();
        cpu_read("wrap_rd0",  8'h00, 8'hEE);
        cpu_read("wrap_rd1",  8'h01, 8'h3D);
        cpu_read("wrap_rdff", 8'hFF, 8'hC3);
        chk("col_sticky", S_COL, 8'h01);
        tick();

        load_en = 1'b1;
        tick();
        pulse(8'h91); pulse(8'h92);
        chk("mid_la2", S_LA, 8'h02);
        tick();
        addr = 8'h10; ram_r = 1'b0; rst = 1'b0; load_en = 1'b0;
        chk("mid_rst_z", S_Z, 8'h00);
        tick();
        chk("mid_z_held", S_Z,    8'h00);
        chk("mid_la",     S_LA,   8'h00);
        chk("mid_col",    S_COL,  8'h00);
        chk("mid_busy",   S_BUSY, {7'd0, RST_BUSY});
        ram_r = 1'b1;
        tick();
        rst = 1'b1;
`ifdef RAM_CLEAR_EN
        wait_clear();
        cpu_read("mid_rd0",  8'h00, 8'h00);
        cpu_read("mid_rd1",  8'h01, 8'h00);
        cpu_read("mid_rd20", 8'h20, 8'h00);
`else
        tick();
        cpu_read("mid_rd0", 8'h00, 8'h91);
        cpu_read("mid_rd1", 8'h01, 8'h92);
`endif

        tick(); tick();
        if (sb.size() != 0) begin
            $display("FAIL drain: got %0d pending want 0", sb.size());
            n_bad++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
